// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Contents:
//   scan_state_t - scan FSM state encoding (IDLE, GUARD, SHOW)
//   SEG_DASH     - glyph for non-decimal codes 10..15
//   SEG_BLANK    - all segments off
//   SEG_TABLE    - 16-entry code-to-segment table, bit 0 = segment a, bit 6 = segment g
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Packed so that SEG_TABLE[code] selects the glyph directly; entry 15 comes first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, // 15..10
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder.
// Ports:
//   code - 4-bit input code (0..9 decimal glyphs, 10..15 dash)
//   seg  - 7-bit active-high segments, seg[0]=a .. seg[6]=g
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[code];

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed seven-segment display scanner.
// Each digit is driven for PRESCALE cycles, separated by GUARD_CYC cycles with
// every anode off so the previous digit cannot ghost into the next one.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   digit_in    - DIGITS packed BCD digits, digit 0 in bits [3:0]
//   dp_in       - decimal-point request per digit
//   load        - strobe capturing digit_in/dp_in into the shadow register
//   blank_lz    - leading-zero blanking enable
//   seg, dp, an - registered segment, decimal point and one-hot anode outputs
//   frame_done  - one-cycle pulse after the last digit of a scan
module bcd_seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 50000,
    parameter int GUARD_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_t           state_reg;
    logic [IW-1:0]         idx_reg;
    logic [PW-1:0]         pre_cnt_reg;
    logic [GW-1:0]         guard_cnt_reg;
    logic [4*DIGITS-1:0]   shadow_digit_reg;
    logic [DIGITS-1:0]     shadow_dp_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;
    logic [DIGITS-1:0]     an_reg;
    logic                  frame_done_reg;

    // Per-digit views of the shadow register.
    logic [3:0]            digit_arr [DIGITS];
    logic [DIGITS:0]       zero_above;   // zero_above[i]: digits i..DIGITS-1 are all zero
    logic [DIGITS-1:0]     lz_blank;     // digit i qualifies as a leading zero
    logic [DIGITS-1:0]     an_onehot;

    assign zero_above[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_arr[gi]  = shadow_digit_reg[4*gi +: 4];
            assign zero_above[gi] = (digit_arr[gi] == 4'd0) && zero_above[gi+1];
            assign an_onehot[gi]  = (idx_reg == IW'(gi));
            // The least-significant digit always shows, so a value of zero reads "0".
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = zero_above[gi];
            end
        end
    endgenerate

    logic [3:0] cur_code;
    logic [6:0] cur_seg;
    logic       cur_blank;

    assign cur_code  = digit_arr[idx_reg];
    assign cur_blank = blank_lz && lz_blank[idx_reg];

    bcd_to_seg u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= '0;
            pre_cnt_reg      <= '0;
            guard_cnt_reg    <= '0;
            shadow_digit_reg <= '0;
            shadow_dp_reg    <= '0;
            seg_reg          <= SEG_BLANK;
            dp_reg           <= 1'b0;
            an_reg           <= '0;
            frame_done_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            // The shadow is only consulted on GUARD->SHOW, so loading mid-SHOW
            // leaves the driven digit untouched.
            if (load) begin
                shadow_digit_reg <= digit_in;
                shadow_dp_reg    <= dp_in;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        state_reg     <= ST_GUARD;
                        idx_reg       <= '0;
                        guard_cnt_reg <= '0;
                    end
                end

                ST_GUARD: begin
                    if (guard_cnt_reg == GUARD_LAST) begin
                        state_reg     <= ST_SHOW;
                        guard_cnt_reg <= '0;
                        pre_cnt_reg   <= '0;
                        seg_reg       <= cur_blank ? SEG_BLANK : cur_seg;
                        dp_reg        <= shadow_dp_reg[idx_reg];
                        an_reg        <= an_onehot;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + 1'b1;
                    end
                end

                ST_SHOW: begin
                    if (pre_cnt_reg == PRE_LAST) begin
                        state_reg      <= ST_GUARD;
                        pre_cnt_reg    <= '0;
                        seg_reg        <= SEG_BLANK;
                        dp_reg         <= 1'b0;
                        an_reg         <= '0;
                        frame_done_reg <= (idx_reg == IDX_LAST);
                        idx_reg        <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                    end else begin
                        pre_cnt_reg <= pre_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan with DIGITS=4, PRESCALE=4, GUARD_CYC=1.
// The driver pushes the hand-computed glyph expected for each digit visit;
// the monitor pops one entry whenever a new digit starts being driven and
// also checks show length, guard length, output hold and frame_done spacing.
module tb_bcd_seg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digit_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    bcd_seg_scan #(
        .DIGITS    (4),
        .PRESCALE  (4),
        .GUARD_CYC (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_in   (digit_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; rst is sampled at the next rising edge.
    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge after the edge that sampled load (edge E0).
    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic blz);
        @(negedge clk);
        digit_in = d;
        dp_in    = p;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic       in_show  = 1'b0;
    int         run_len  = 0;
    int         gap_len  = -1;
    int         fd_since = 0;
    logic       fd_seen  = 1'b0;
    logic [3:0] last_an  = '0;
    exp_t       cur;

    always @(posedge clk) begin
        #1;
        if (rst === 1'b1) begin
            in_show  = 1'b0;
            run_len  = 0;
            gap_len  = -1;
            fd_since = 0;
            fd_seen  = 1'b0;
            last_an  = '0;
        end else begin
            fd_since++;
            if (an !== 4'b0000 && !$isunknown(an)) begin
                if (!in_show) begin
                    if (gap_len >= 0) chk("guard_len", gap_len, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_show_an", {28'd0, an}, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("show_an", {28'd0, an}, {28'd0, e.an});
                        chk("show_seg", {25'd0, seg}, {25'd0, e.seg});
                        chk("show_dp", {31'd0, dp}, {31'd0, e.dp});
                    end
                    cur.an  = an;
                    cur.seg = seg;
                    cur.dp  = dp;
                    in_show = 1'b1;
                    run_len = 1;
                end else begin
                    run_len++;
                    chk("show_hold", {20'd0, an, seg, dp}, {20'd0, cur.an, cur.seg, cur.dp});
                end
            end else begin
                if (in_show) begin
                    chk("show_len", run_len, 4);
                    chk("guard_seg_dp", {24'd0, seg, dp}, 32'd0);
                    in_show = 1'b0;
                    last_an = cur.an;
                    gap_len = 1;
                end else if (gap_len >= 0) begin
                    gap_len++;
                end
            end
            if (frame_done === 1'b1) begin
                chk("frame_done_an", {28'd0, an}, 32'd0);
                chk("frame_done_last_digit", {28'd0, last_an}, 32'h8);
                if (fd_seen) chk("frame_period", fd_since, 20);
                fd_seen  = 1'b1;
                fd_since = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        digit_in = '0;
        dp_in    = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing driven without a load.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_outputs", {20'd0, an, seg, dp, frame_done}, 32'd0);
        end

        // 1234, two frames, dp on digit 1.
        for (int f = 0; f < 2; f++) begin
            push(4'b0001, 7'b1100110, 1'b0);
            push(4'b0010, 7'b1001111, 1'b1);
            push(4'b0100, 7'b1011011, 1'b0);
            push(4'b1000, 7'b0000110, 1'b0);
        end
        do_load(16'h1234, 4'b0010, 1'b0);
        repeat (40) @(negedge clk);
        do_reset();

        // 0070 with blanking: blanked digit 3 still carries its dp.
        push(4'b0001, 7'b0111111, 1'b0);
        push(4'b0010, 7'b0000111, 1'b0);
        push(4'b0100, 7'b0000000, 1'b0);
        push(4'b1000, 7'b0000000, 1'b1);
        do_load(16'h0070, 4'b1000, 1'b1);
        repeat (20) @(negedge clk);
        do_reset();

        // A00F: non-decimal codes show a dash.
        push(4'b0001, 7'b1000000, 1'b0);
        push(4'b0010, 7'b0111111, 1'b0);
        push(4'b0100, 7'b0111111, 1'b0);
        push(4'b1000, 7'b1000000, 1'b0);
        do_load(16'hA00F, 4'b0000, 1'b0);
        repeat (20) @(negedge clk);
        do_reset();

        // 0100 with blanking: an interior zero below a nonzero digit is kept.
        push(4'b0001, 7'b0111111, 1'b0);
        push(4'b0010, 7'b0111111, 1'b0);
        push(4'b0100, 7'b0000110, 1'b0);
        push(4'b1000, 7'b0000000, 1'b0);
        do_load(16'h0100, 4'b0000, 1'b1);
        repeat (20) @(negedge clk);
        do_reset();

        // 1234 then 5678 loaded on the 2nd SHOW cycle of digit 0.
        push(4'b0001, 7'b1100110, 1'b0);
        push(4'b0010, 7'b0000111, 1'b0);
        push(4'b0100, 7'b1111101, 1'b0);
        push(4'b1000, 7'b1101101, 1'b0);
        do_load(16'h1234, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        digit_in = 16'h5678;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        repeat (17) @(negedge clk);
        do_reset();

        // Reset during the 3rd SHOW cycle of digit 2, then stay idle.
        push(4'b0001, 7'b1100110, 1'b0);
        push(4'b0010, 7'b1001111, 1'b0);
        push(4'b0100, 7'b1011011, 1'b0);
        do_load(16'h1234, 4'b0000, 1'b0);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_show_an", {28'd0, an}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("idle_after_rst", {20'd0, an, seg, dp, frame_done}, 32'd0);
        end

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits scanned, range 1..8.
REQ-002 Parameter PRESCALE, default 50000: clk cycles each digit is driven per visit, minimum 2.
REQ-003 Parameter GUARD_CYC, default 16: all-anodes-off anti-ghost cycles between digits, minimum 1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 digit_in  input  4*DIGITS  BCD digits; digit i occupies bits [4i+3:4i]; digit 0 is least significant.
REQ-007 dp_in  input  DIGITS  decimal-point request per digit.
REQ-008 load  input  1  single-cycle strobe capturing digit_in and dp_in into the shadow register.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 seg  output  7  active-high segments; seg[0]=a through seg[6]=g.
REQ-011 dp  output  1  active-high decimal point for the driven digit.
REQ-012 an  output  DIGITS  active-high one-hot digit enable; all zero when no digit is driven.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 FSM states shall be IDLE, GUARD and SHOW, plus a digit index idx in the range 0..DIGITS-1.
REQ-015 A load sampled high shall copy digit_in and dp_in to the shadow register at that edge, in any state.
REQ-016 In IDLE, a load shall also transition the FSM to GUARD with idx=0; without a load, IDLE shall persist.
REQ-017 GUARD shall last exactly GUARD_CYC cycles with an=0, seg=0 and dp=0, then transition to SHOW.
REQ-018 On the GUARD->SHOW edge, seg, dp and an shall be registered from shadow digit idx, and blank_lz shall be sampled; they shall hold for the entire SHOW.
REQ-019 SHOW shall last exactly PRESCALE cycles, then transition to GUARD with idx incremented, wrapping from DIGITS-1 to 0.
REQ-020 frame_done shall be high for the single cycle following the SHOW->GUARD edge taken when idx=DIGITS-1.
REQ-021 Digit period shall be PRESCALE+GUARD_CYC cycles; frame period shall be DIGITS*(PRESCALE+GUARD_CYC) cycles.
REQ-022 Codes 0-9 shall use the standard seven-segment glyphs; codes 10-15 shall display a dash (seg=7'b1000000).
REQ-023 With blank_lz=1, digit i>0 shall be blanked (seg=0) when it and every more-significant shadow digit equal 0; digit 0 shall never be blanked.
REQ-024 A blanked digit shall still assert its an bit and its dp, so scan timing stays uniform.
REQ-025 A load during SHOW shall not alter the digit currently driven; the new data shall appear from the next GUARD->SHOW edge.
REQ-026 The prescaler and guard counters shall be sized by clog2 of their parameter and shall never count past the terminal value.

Reset
REQ-027 When rst is high at an edge: state=IDLE, idx=0, counters=0, shadow=0, seg=0, dp=0, an=0 and frame_done=0.
REQ-028 rst shall override a simultaneous load, and asserting rst mid-SHOW or mid-GUARD shall blank all outputs from the next cycle.

Structure
REQ-029 The state encoding, the 16-entry BCD-to-segment table and the dash constant shall reside in the shared package seg_pkg.
REQ-030 The combinational decoder shall be the sole sub-module, bcd_to_seg (4-bit code in, 7-bit segments out).

Verification (PRESCALE=4, GUARD_CYC=1, DIGITS=4)
REQ-031 rst, then 50 cycles with no load -> an=0000, seg=0 and frame_done=0 throughout.
REQ-032 load with digit_in=16'h1234, blank_lz=0 -> one GUARD cycle, then an=0001 with seg=7'b1100110 for 4 cycles, GUARD, then an=0010 with seg=7'b1001111, and so on; frame_done pulses every 20 cycles.
REQ-033 load 16'h0070, blank_lz=1 -> digits 3 and 2 show seg=0 with their an bit set, digit 1 shows seg=7'b0000111, digit 0 shows seg=7'b0111111.
REQ-034 load 16'hA00F, blank_lz=0 -> digits 3 and 0 show seg=7'b1000000, digits 2 and 1 show seg=7'b0111111.
REQ-035 load 16'h1234, then load 16'h5678 on the 2nd SHOW cycle of digit 0 -> digit 0 remains seg=7'b1100110, and digit 1 shows 7 (seg=7'b0000111).
REQ-036 rst asserted during the 3rd SHOW cycle of digit 2 -> an=0000 on the next cycle and the FSM stays in IDLE until the next load.
